// File: rtl/svif_multichan_top_if.sv
// Bundle of channel, counter-control and pass-through signals for svif_multichan_top.
// The master side drives symbols and controls; the slave side (the block) returns results.
interface svif_multichan_top_if #(
  parameter int NCH   = 4,
  parameter int SIG_W = 2,
  parameter int CNT_W = 22,
  parameter int PT_W  = 16
);
  logic [NCH*SIG_W-1:0] sig;
  logic [NCH-1:0]       flip;
  logic                 setting;
  logic [2:0]           other_setting;
  logic [PT_W-1:0]      pass_in;
  logic                 pass_vld_in;
  logic [NCH*SIG_W-1:0] sig_out;
  logic [CNT_W-1:0]     out_other;
  logic [PT_W-1:0]      pass_out;
  logic                 pass_vld_out;
  logic                 mode_run;

  modport master (
    output sig, flip, setting, other_setting, pass_in, pass_vld_in,
    input  sig_out, out_other, pass_out, pass_vld_out, mode_run
  );

  modport slave (
    input  sig, flip, setting, other_setting, pass_in, pass_vld_in,
    output sig_out, out_other, pass_out, pass_vld_out, mode_run
  );
endinterface

// File: rtl/svif_multichan_top.sv
// Multi-channel symbol register with optional per-channel inversion, a step counter,
// a valid-tagged pass-through pipe and a WARM/RUN/FREEZE mode FSM.
module svif_multichan_top #(
  parameter int NCH      = 4,
  parameter int SIG_W    = 2,
  parameter int CNT_W    = 22,
  parameter int SAT      = 0,
  parameter int PT_W     = 16,
  parameter int PT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  svif_multichan_top_if.slave  bus,
  output logic [1:0]           stateDbg
);

  typedef enum logic [1:0] {
    WARM   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam int SW = CNT_W + 1;

  state_t               stateQ, stateNext;
  logic                 modeRunQ;
  logic [NCH*SIG_W-1:0] sigQ, sigNext;
  logic [CNT_W-1:0]     cntQ, cntNext;
  logic [SW-1:0]        cntSum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ   <= WARM;
      modeRunQ <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      modeRunQ <= (stateNext == RUN);
    end
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      WARM:    stateNext = RUN;
      RUN:     stateNext = bus.setting ? FREEZE : RUN;
      FREEZE:  stateNext = bus.setting ? FREEZE : RUN;
      default: stateNext = WARM;
    endcase
  end

  always_comb begin
    sigNext = '0;
    for (int c = 0; c < NCH; c++) begin
      sigNext[c*SIG_W +: SIG_W] = bus.flip[c] ? ~bus.sig[c*SIG_W +: SIG_W]
                                               :  bus.sig[c*SIG_W +: SIG_W];
    end
  end

  // Sum kept one bit wider so the carry decides wrap versus saturation.
  assign cntSum  = SW'(cntQ) + SW'(bus.other_setting) + SW'(1);
  assign cntNext = ((SAT != 0) && cntSum[CNT_W]) ? '1 : cntSum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sigQ <= '0;
      cntQ <= '0;
    end else if (stateQ == RUN) begin
      sigQ <= sigNext;
      cntQ <= cntNext;
    end
  end

  assign bus.sig_out   = sigQ;
  assign bus.out_other = cntQ;
  assign bus.mode_run  = modeRunQ;
  assign stateDbg      = stateQ;

  // pass_vld_in qualifies pass_in; there is no ready, so the pipe never stalls
  // and data moves every cycle with its valid bit alongside.
  generate
    if (PT_DEPTH == 0) begin : gNoPipe
      assign bus.pass_out     = rst ? bus.pass_in : '0;
      assign bus.pass_vld_out = rst ? bus.pass_vld_in : 1'b0;
    end else begin : gPipe
      logic [PT_W-1:0]     ptData [PT_DEPTH];
      logic [PT_DEPTH-1:0] ptVld;

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < PT_DEPTH; i++) ptData[i] <= '0;
          ptVld <= '0;
        end else begin
          ptData[0] <= bus.pass_in;
          ptVld[0]  <= bus.pass_vld_in;
          for (int i = 1; i < PT_DEPTH; i++) begin
            ptData[i] <= ptData[i-1];
            ptVld[i]  <= ptVld[i-1];
          end
        end
      end

      assign bus.pass_out     = ptData[PT_DEPTH-1];
      assign bus.pass_vld_out = ptVld[PT_DEPTH-1];
    end
  endgenerate

endmodule

// File: tb/tb_svif_multichan_top.sv
// Directed bench: a wrapping/piped instance and a saturating/combinational-pass instance
// share one stimulus set; each scenario task checks its own expected values.
module tb_svif_multichan_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sig;
  logic [3:0]  flip;
  logic        setting;
  logic [2:0]  otherSetting;
  logic [15:0] passIn;
  logic        passVldIn;
  logic [1:0]  stateDbgW, stateDbgS;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  svif_multichan_top_if #(.NCH(4), .SIG_W(2), .CNT_W(4), .PT_W(16)) busW ();
  svif_multichan_top_if #(.NCH(4), .SIG_W(2), .CNT_W(4), .PT_W(16)) busS ();

  assign busW.sig = sig;            assign busS.sig = sig;
  assign busW.flip = flip;          assign busS.flip = flip;
  assign busW.setting = setting;    assign busS.setting = setting;
  assign busW.other_setting = otherSetting;
  assign busS.other_setting = otherSetting;
  assign busW.pass_in = passIn;     assign busS.pass_in = passIn;
  assign busW.pass_vld_in = passVldIn;
  assign busS.pass_vld_in = passVldIn;

  svif_multichan_top #(.NCH(4), .SIG_W(2), .CNT_W(4), .SAT(0), .PT_W(16), .PT_DEPTH(2)) dutW (
    .clk(clk), .rst(rst), .bus(busW.slave), .stateDbg(stateDbgW)
  );

  svif_multichan_top #(.NCH(4), .SIG_W(2), .CNT_W(4), .SAT(1), .PT_W(16), .PT_DEPTH(0)) dutS (
    .clk(clk), .rst(rst), .bus(busS.slave), .stateDbg(stateDbgS)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [29:0] obs;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sig = 8'($urandom_range(0, 255));
      flip = 4'($urandom_range(0, 15));
      setting = 1'($urandom_range(0, 1));
      otherSetting = 3'($urandom_range(0, 7));
      passIn = 16'($urandom_range(0, 65535));
      passVldIn = 1'($urandom_range(0, 1));
      step();
      obs = {busW.sig_out, busW.out_other, busW.pass_out, busW.pass_vld_out, busW.mode_run};
      checks++;
      if (obs !== 30'h0 || stateDbgW !== 2'd0) begin
        errors++;
        $display("FAIL reset_w cycle %0d: got %h state %0d, want 0 state 0", i, obs, stateDbgW);
      end
      obs = {busS.sig_out, busS.out_other, busS.pass_out, busS.pass_vld_out, busS.mode_run};
      checks++;
      if (obs !== 30'h0) begin
        errors++;
        $display("FAIL reset_s cycle %0d: got %h, want 0", i, obs);
      end
    end
    sig = 8'h00; flip = 4'h0; setting = 1'b0; otherSetting = 3'd0;
    passIn = 16'h0000; passVldIn = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (busW.mode_run !== 1'b0 || stateDbgW !== 2'd0) begin
      errors++;
      $display("FAIL warm_cycle: mode_run %b state %0d, want 0 state 0", busW.mode_run, stateDbgW);
    end
    step();
    checks++;
    if (busW.mode_run !== 1'b1 || busS.mode_run !== 1'b1 || stateDbgW !== 2'd1) begin
      errors++;
      $display("FAIL enter_run: mode_run w%b s%b state %0d, want 1 1 state 1",
               busW.mode_run, busS.mode_run, stateDbgW);
    end
    checks++;
    if (busW.out_other !== 4'd0 || busS.out_other !== 4'd0) begin
      errors++;
      $display("FAIL warm_no_count: got w%0d s%0d, want 0", busW.out_other, busS.out_other);
    end
  endtask

  task automatic test_channel();
    logic [7:0] vecSig [2]  = '{8'b11_10_01_00, 8'b00_01_10_11};
    logic [3:0] vecFlip [2] = '{4'b0101, 4'b1111};
    logic [7:0] vecExp [2]  = '{8'b11_01_01_11, 8'b11_10_01_00};
    for (int i = 0; i < 2; i++) begin
      sig = vecSig[i];
      flip = vecFlip[i];
      step();
      checks++;
      if (busW.sig_out !== vecExp[i] || busS.sig_out !== vecExp[i]) begin
        errors++;
        $display("FAIL channel vec %0d: got w%b s%b, want %b", i, busW.sig_out, busS.sig_out, vecExp[i]);
      end
    end
  endtask

  task automatic test_counter();
    logic [3:0] expW [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};
    logic [3:0] expS [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};
    rst = 1'b0;
    step();
    rst = 1'b1;
    otherSetting = 3'd2;
    step();
    checks++;
    if (busW.out_other !== 4'd0 || busS.out_other !== 4'd0) begin
      errors++;
      $display("FAIL counter_start: got w%0d s%0d, want 0", busW.out_other, busS.out_other);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (busW.out_other !== expW[i]) begin
        errors++;
        $display("FAIL counter_wrap step %0d: got %0d, want %0d", i, busW.out_other, expW[i]);
      end
      checks++;
      if (busS.out_other !== expS[i]) begin
        errors++;
        $display("FAIL counter_sat step %0d: got %0d, want %0d", i, busS.out_other, expS[i]);
      end
    end
  endtask

  task automatic test_freeze();
    otherSetting = 3'd1;
    sig = 8'h1B;
    flip = 4'h0;
    setting = 1'b1;
    step();
    checks++;
    if (busW.out_other !== 4'd4 || busS.out_other !== 4'd15 || busW.sig_out !== 8'h1B
        || busW.mode_run !== 1'b0) begin
      errors++;
      $display("FAIL freeze_entry: cnt w%0d s%0d sig %h run %b, want 4 15 1b 0",
               busW.out_other, busS.out_other, busW.sig_out, busW.mode_run);
    end
    for (int i = 0; i < 4; i++) begin
      sig = 8'hFF;
      flip = 4'hF;
      step();
      checks++;
      if (busW.out_other !== 4'd4 || busW.sig_out !== 8'h1B || busW.mode_run !== 1'b0
          || stateDbgW !== 2'd2) begin
        errors++;
        $display("FAIL freeze_hold %0d: cnt %0d sig %h run %b state %0d, want 4 1b 0 2",
                 i, busW.out_other, busW.sig_out, busW.mode_run, stateDbgW);
      end
    end
    setting = 1'b0;
    step();
    checks++;
    if (busW.out_other !== 4'd4 || busW.sig_out !== 8'h1B || busW.mode_run !== 1'b1) begin
      errors++;
      $display("FAIL freeze_exit: cnt %0d sig %h run %b, want 4 1b 1",
               busW.out_other, busW.sig_out, busW.mode_run);
    end
    step();
    checks++;
    if (busW.out_other !== 4'd6 || busS.out_other !== 4'd15 || busW.sig_out !== 8'h00) begin
      errors++;
      $display("FAIL resume: cnt w%0d s%0d sig %h, want 6 15 00",
               busW.out_other, busS.out_other, busW.sig_out);
    end
  endtask

  task automatic test_pass();
    logic [15:0] vecData [3] = '{16'hA5A5, 16'h1234, 16'h0000};
    logic        vecVld [3]  = '{1'b1, 1'b0, 1'b0};
    logic [16:0] exp;
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b1, 16'hA5A5});
    exp_q.push_back({1'b0, 16'h1234});
    setting = 1'b1;
    for (int i = 0; i < 3; i++) begin
      passIn = vecData[i];
      passVldIn = vecVld[i];
      #1;
      checks++;
      if (busS.pass_out !== vecData[i] || busS.pass_vld_out !== vecVld[i]) begin
        errors++;
        $display("FAIL pass_comb %0d: got %h/%b, want %h/%b",
                 i, busS.pass_out, busS.pass_vld_out, vecData[i], vecVld[i]);
      end
      step();
      exp = exp_q.pop_front();
      checks++;
      if ({busW.pass_vld_out, busW.pass_out} !== exp || busW.mode_run !== 1'b0) begin
        errors++;
        $display("FAIL pass_pipe edge %0d: got %b/%h run %b, want %b/%h run 0",
                 i + 1, busW.pass_vld_out, busW.pass_out, busW.mode_run, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [29:0] obs;
    setting = 1'b0;
    sig = 8'h3C;
    flip = 4'h0;
    otherSetting = 3'd3;
    passIn = 16'hBEEF;
    passVldIn = 1'b1;
    step();
    step();
    step();
    checks++;
    if (busW.pass_out !== 16'hBEEF || busW.pass_vld_out !== 1'b1 || busW.sig_out !== 8'h3C) begin
      errors++;
      $display("FAIL pre_reset: pass %h/%b sig %h, want beef/1 3c",
               busW.pass_out, busW.pass_vld_out, busW.sig_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busS.pass_out !== 16'h0000 || busS.pass_vld_out !== 1'b0) begin
      errors++;
      $display("FAIL comb_pass_forced: got %h/%b, want 0000/0", busS.pass_out, busS.pass_vld_out);
    end
    step();
    obs = {busW.sig_out, busW.out_other, busW.pass_out, busW.pass_vld_out, busW.mode_run};
    checks++;
    if (obs !== 30'h0 || stateDbgW !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_w: got %h state %0d, want 0 state 0", obs, stateDbgW);
    end
    obs = {busS.sig_out, busS.out_other, busS.pass_out, busS.pass_vld_out, busS.mode_run};
    checks++;
    if (obs !== 30'h0) begin
      errors++;
      $display("FAIL mid_reset_s: got %h, want 0", obs);
    end
    rst = 1'b1;
    passIn = 16'h0000;
    passVldIn = 1'b0;
    step();
    checks++;
    if (busW.pass_out !== 16'h0000 || busW.pass_vld_out !== 1'b0 || busW.out_other !== 4'd0
        || busW.mode_run !== 1'b1) begin
      errors++;
      $display("FAIL pipe_flushed: pass %h/%b cnt %0d run %b, want 0000/0 0 1",
               busW.pass_out, busW.pass_vld_out, busW.out_other, busW.mode_run);
    end
  endtask

  initial begin
    rst = 1'b0;
    sig = '0; flip = '0; setting = 1'b0; otherSetting = '0;
    passIn = '0; passVldIn = 1'b0;
    test_reset();
    test_channel();
    test_counter();
    test_freeze();
    test_pass();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
